ram_decryptor: RTL and testbench

//  RC4 PRGA stage; runs after the KSA shuffle has filled the S RAM.

---
 rtl/rc4_pkg.sv | 33 +++
 rtl/trap_edge.sv | 27 ++
 rtl/ram_decryptor.sv | 197 +++++++++++++++++++
 tb/tb_ram_decryptor.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_pkg
//  Description : Shared RC4 PRGA state encoding and printable-byte classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
package rc4_pkg;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        INC_I   = 4'd1,
        WAIT_SI = 4'd2,
        RD_SI   = 4'd3,
        WAIT_SJ = 4'd4,
        RD_SJ   = 4'd5,
        WR_I    = 4'd6,
        WR_J    = 4'd7,
        WAIT_F  = 4'd8,
        RD_F    = 4'd9,
        NEXT    = 4'd10,
        DONE    = 4'd11
    } prga_state_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b == CHAR_SPACE) || ((b >= CHAR_LO) && (b <= CHAR_HI));
    endfunction

endpackage
`default_nettype wire

// File: rtl/trap_edge.sv
`default_nettype none
// ============================================================================
//  Module      : trap_edge
//  Description : Single-cycle pulse on each rising edge of in_sig.
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_edge (
    input  logic clk,
    input  logic reset,
    input  logic in_sig,
    output logic rise
);

    logic r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= in_sig;
        end
    end

    assign rise = in_sig & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/ram_decryptor.sv
`default_nettype none
// ============================================================================
//  Module      : ram_decryptor
//  Description : RC4 PRGA - swaps S, XORs keystream with the encrypted ROM and
//                writes plaintext, flagging non-printable output bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_decryptor
    import rc4_pkg::*;
#(
    parameter int RAM_WIDTH        = 8,
    parameter int RAM_LENGTH       = 8,
    parameter int MSG_ADDR_WIDTH   = 5,
    parameter int MSG_LENGTH       = 32,
    parameter int ABORT_ON_INVALID = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      finished,
    output logic                      valid,
    input  logic [RAM_WIDTH-1:0]      s_out,
    output logic [RAM_LENGTH-1:0]     s_addr,
    output logic [RAM_WIDTH-1:0]      s_in,
    output logic                      s_wren,
    input  logic [RAM_WIDTH-1:0]      enc_out,
    output logic [MSG_ADDR_WIDTH-1:0] enc_addr,
    output logic [MSG_ADDR_WIDTH-1:0] dec_addr,
    output logic [RAM_WIDTH-1:0]      dec_in,
    output logic                      dec_wren
);

    localparam logic [MSG_ADDR_WIDTH-1:0] c_last_k = MSG_ADDR_WIDTH'(MSG_LENGTH - 1);

    prga_state_t r_state, w_state;

    logic [RAM_LENGTH-1:0]     r_i, w_i, r_j, w_j, r_s_addr, w_s_addr;
    logic [MSG_ADDR_WIDTH-1:0] r_k, w_k, r_enc_addr, w_enc_addr, r_dec_addr, w_dec_addr;
    logic [RAM_WIDTH-1:0]      r_si, w_si, r_sj, w_sj, r_s_in, w_s_in, r_dec_in, w_dec_in;
    logic                      r_s_wren, w_s_wren, r_dec_wren, w_dec_wren;
    logic                      r_finished, w_finished, r_valid, w_valid;

    logic                      w_start_rise;
    logic [RAM_WIDTH-1:0]      w_f_byte;
    logic                      w_stop;

    trap_edge u_start_edge (
        .clk    (clk),
        .reset  (reset),
        .in_sig (start),
        .rise   (w_start_rise)
    );

    assign w_f_byte = s_out ^ enc_out;
    // r_valid already reflects the byte written in RD_F when NEXT evaluates this
    assign w_stop   = (r_k == c_last_k) || ((ABORT_ON_INVALID != 0) && !r_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    always_comb begin
        w_state = r_state;
        case (r_state)
            IDLE:    if (w_start_rise) w_state = INC_I;
            INC_I:   w_state = WAIT_SI;
            WAIT_SI: w_state = RD_SI;
            RD_SI:   w_state = WAIT_SJ;
            WAIT_SJ: w_state = RD_SJ;
            RD_SJ:   w_state = WR_I;
            WR_I:    w_state = WR_J;
            WR_J:    w_state = WAIT_F;
            WAIT_F:  w_state = RD_F;
            RD_F:    w_state = NEXT;
            NEXT:    w_state = w_stop ? DONE : INC_I;
            DONE:    w_state = IDLE;
            default: w_state = IDLE;
        endcase
    end

    always_comb begin
        w_i        = r_i;
        w_j        = r_j;
        w_k        = r_k;
        w_si       = r_si;
        w_sj       = r_sj;
        w_s_addr   = r_s_addr;
        w_s_in     = r_s_in;
        w_s_wren   = r_s_wren;
        w_enc_addr = r_enc_addr;
        w_dec_addr = r_dec_addr;
        w_dec_in   = r_dec_in;
        w_dec_wren = r_dec_wren;
        w_finished = r_finished;
        w_valid    = r_valid;
        case (r_state)
            IDLE: begin
                if (w_start_rise) begin
                    w_i        = '0;
                    w_j        = '0;
                    w_k        = '0;
                    w_si       = '0;
                    w_sj       = '0;
                    w_finished = 1'b0;
                    w_valid    = 1'b1;
                end
            end
            INC_I: begin
                w_i      = r_i + 1'b1;
                w_s_addr = r_i + 1'b1;
            end
            RD_SI: begin
                w_si     = s_out;
                w_j      = r_j + RAM_LENGTH'(s_out);
                w_s_addr = r_j + RAM_LENGTH'(s_out);
            end
            RD_SJ: begin
                w_sj     = s_out;
                w_s_addr = r_i;
                w_s_in   = s_out;
                w_s_wren = 1'b1;
            end
            WR_I: begin
                w_s_addr = r_j;
                w_s_in   = r_si;
                w_s_wren = 1'b1;
            end
            WR_J: begin
                w_s_wren   = 1'b0;
                w_s_addr   = RAM_LENGTH'(r_si + r_sj);
                w_enc_addr = r_k;
            end
            RD_F: begin
                w_dec_addr = r_k;
                w_dec_in   = w_f_byte;
                w_dec_wren = 1'b1;
                if (!is_printable(8'(w_f_byte))) w_valid = 1'b0;
            end
            NEXT: begin
                w_dec_wren = 1'b0;
                if (!w_stop) w_k = r_k + 1'b1;
            end
            DONE:    w_finished = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_si       <= '0;
            r_sj       <= '0;
            r_s_addr   <= '0;
            r_s_in     <= '0;
            r_s_wren   <= 1'b0;
            r_enc_addr <= '0;
            r_dec_addr <= '0;
            r_dec_in   <= '0;
            r_dec_wren <= 1'b0;
            r_finished <= 1'b0;
            r_valid    <= 1'b1;
        end else begin
            r_i        <= w_i;
            r_j        <= w_j;
            r_k        <= w_k;
            r_si       <= w_si;
            r_sj       <= w_sj;
            r_s_addr   <= w_s_addr;
            r_s_in     <= w_s_in;
            r_s_wren   <= w_s_wren;
            r_enc_addr <= w_enc_addr;
            r_dec_addr <= w_dec_addr;
            r_dec_in   <= w_dec_in;
            r_dec_wren <= w_dec_wren;
            r_finished <= w_finished;
            r_valid    <= w_valid;
        end
    end

    assign finished = r_finished;
    assign valid    = r_valid;
    assign s_addr   = r_s_addr;
    assign s_in     = r_s_in;
    assign s_wren   = r_s_wren;
    assign enc_addr = r_enc_addr;
    assign dec_addr = r_dec_addr;
    assign dec_in   = r_dec_in;
    assign dec_wren = r_dec_wren;

endmodule
`default_nettype wire

// File: tb/tb_ram_decryptor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_decryptor
//  Description : Self-checking bench: two decryptor instances (short/abort and
//                full-length/no-abort) against a reference RC4 PRGA scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_decryptor;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic       start_a, finished_a, valid_a, s_wren_a, dec_wren_a;
    logic [7:0] s_out_a, s_addr_a, s_in_a, enc_out_a, dec_in_a;
    logic [4:0] enc_addr_a, dec_addr_a;
    logic       start_b, finished_b, valid_b, s_wren_b, dec_wren_b;
    logic [7:0] s_out_b, s_addr_b, s_in_b, enc_out_b, dec_in_b;
    logic [4:0] enc_addr_b, dec_addr_b;

    ram_decryptor #(.RAM_WIDTH(8), .RAM_LENGTH(8), .MSG_ADDR_WIDTH(5),
                    .MSG_LENGTH(2), .ABORT_ON_INVALID(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .finished(finished_a), .valid(valid_a),
        .s_out(s_out_a), .s_addr(s_addr_a), .s_in(s_in_a), .s_wren(s_wren_a),
        .enc_out(enc_out_a), .enc_addr(enc_addr_a),
        .dec_addr(dec_addr_a), .dec_in(dec_in_a), .dec_wren(dec_wren_a)
    );

    ram_decryptor #(.RAM_WIDTH(8), .RAM_LENGTH(8), .MSG_ADDR_WIDTH(5),
                    .MSG_LENGTH(32), .ABORT_ON_INVALID(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .finished(finished_b), .valid(valid_b),
        .s_out(s_out_b), .s_addr(s_addr_b), .s_in(s_in_b), .s_wren(s_wren_b),
        .enc_out(enc_out_b), .enc_addr(enc_addr_b),
        .dec_addr(dec_addr_b), .dec_in(dec_in_b), .dec_wren(dec_wren_b)
    );

    // Synchronous memories with registered read data
    logic [7:0] s_mem_a [256];
    logic [7:0] s_mem_b [256];
    logic [7:0] enc_mem_a [32];
    logic [7:0] enc_mem_b [32];
    logic [7:0] dec_mem_a [32];
    logic [7:0] dec_mem_b [32];
    logic [7:0] enc_init [32];
    logic       init_a, init_b;

    always @(posedge clk) begin
        if (init_a) begin
            for (int x = 0; x < 256; x++) s_mem_a[x] <= 8'(x);
            for (int x = 0; x < 32; x++) begin
                enc_mem_a[x] <= enc_init[x];
                dec_mem_a[x] <= 8'hFF;
            end
        end else begin
            if (s_wren_a) s_mem_a[s_addr_a] <= s_in_a;
            if (dec_wren_a) dec_mem_a[dec_addr_a] <= dec_in_a;
        end
        s_out_a   <= s_mem_a[s_addr_a];
        enc_out_a <= enc_mem_a[enc_addr_a];
    end

    always @(posedge clk) begin
        if (init_b) begin
            for (int x = 0; x < 256; x++) s_mem_b[x] <= 8'(x);
            for (int x = 0; x < 32; x++) begin
                enc_mem_b[x] <= enc_init[x];
                dec_mem_b[x] <= 8'hFF;
            end
        end else begin
            if (s_wren_b) s_mem_b[s_addr_b] <= s_in_b;
            if (dec_wren_b) dec_mem_b[dec_addr_b] <= dec_in_b;
        end
        s_out_b   <= s_mem_b[s_addr_b];
        enc_out_b <= enc_mem_b[enc_addr_b];
    end

    // Scoreboard: {addr, data} of each expected plaintext write
    logic [12:0] q_a [$];
    logic [12:0] q_b [$];
    logic [12:0] exp_a, exp_b;
    int          wren_cnt_a = 0;
    int          wren_cnt_b = 0;
    logic [7:0]  model_s [256];

    always @(negedge clk) begin
        if (dec_wren_a === 1'b1) begin
            wren_cnt_a++;
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL dec_write_a: unexpected write addr=%0d data=%h, none expected", dec_addr_a, dec_in_a);
            end else begin
                exp_a = q_a.pop_front();
                if ({dec_addr_a, dec_in_a} !== exp_a) begin
                    errors++;
                    $display("FAIL dec_write_a: got addr=%0d data=%h, want addr=%0d data=%h",
                             dec_addr_a, dec_in_a, exp_a[12:8], exp_a[7:0]);
                end
            end
            checks++;
            if (s_wren_a !== 1'b0) begin
                errors++;
                $display("FAIL wren_overlap_a: s_wren=%b, want 0 while dec_wren high", s_wren_a);
            end
        end
    end

    always @(negedge clk) begin
        if (dec_wren_b === 1'b1) begin
            wren_cnt_b++;
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL dec_write_b: unexpected write addr=%0d data=%h, none expected", dec_addr_b, dec_in_b);
            end else begin
                exp_b = q_b.pop_front();
                if ({dec_addr_b, dec_in_b} !== exp_b) begin
                    errors++;
                    $display("FAIL dec_write_b: got addr=%0d data=%h, want addr=%0d data=%h",
                             dec_addr_b, dec_in_b, exp_b[12:8], exp_b[7:0]);
                end
            end
            checks++;
            if (s_wren_b !== 1'b0) begin
                errors++;
                $display("FAIL wren_overlap_b: s_wren=%b, want 0 while dec_wren high", s_wren_b);
            end
        end
    end

    // Reference RC4 PRGA over model_s, starting from i=j=0
    task automatic model_run(input int len, input bit abort, input bit to_b, output bit exp_valid);
        logic [7:0] i, j, t, fi, p;
        i = 8'd0;
        j = 8'd0;
        exp_valid = 1'b1;
        for (int k = 0; k < len; k++) begin
            i = i + 8'd1;
            j = j + model_s[i];
            t = model_s[i];
            model_s[i] = model_s[j];
            model_s[j] = t;
            fi = model_s[i] + model_s[j];
            p = model_s[fi] ^ enc_init[k];
            if (to_b) q_b.push_back({5'(k), p});
            else      q_a.push_back({5'(k), p});
            if (!(p == 8'h20 || (p >= 8'h61 && p <= 8'h7a))) begin
                exp_valid = 1'b0;
                if (abort) break;
            end
        end
    endtask

    task automatic load(input bit to_b);
        for (int x = 0; x < 256; x++) model_s[x] = 8'(x);
        @(negedge clk);
        if (to_b) init_b = 1'b1; else init_a = 1'b1;
        @(negedge clk);
        init_a = 1'b0;
        init_b = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({s_addr_a, s_in_a, s_wren_a, enc_addr_a, dec_addr_a, dec_in_a, dec_wren_a, finished_a, valid_a} !== 37'd1) begin
            errors++;
            $display("FAIL reset_a: outputs=%h, want %h", {s_addr_a, s_in_a, s_wren_a, enc_addr_a,
                     dec_addr_a, dec_in_a, dec_wren_a, finished_a, valid_a}, 37'd1);
        end
        checks++;
        if ({s_addr_b, s_in_b, s_wren_b, enc_addr_b, dec_addr_b, dec_in_b, dec_wren_b, finished_b, valid_b} !== 37'd1) begin
            errors++;
            $display("FAIL reset_b: outputs=%h, want %h", {s_addr_b, s_in_b, s_wren_b, enc_addr_b,
                     dec_addr_b, dec_in_b, dec_wren_b, finished_b, valid_b}, 37'd1);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_identity();
        bit ev;
        int cyc, w0, bad;
        for (int x = 0; x < 32; x++) enc_init[x] = 8'h00;
        enc_init[0] = 8'h63;
        enc_init[1] = 8'h64;
        load(1'b0);
        model_run(2, 1'b1, 1'b0, ev);
        w0 = wren_cnt_a;
        @(negedge clk) start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        cyc = 0;
        while (finished_a !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        checks++; if (cyc != 21) begin errors++; $display("FAIL id_latency: got %0d cycles, want 21", cyc); end
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL id_valid: got %b, want 1", valid_a); end
        checks++; if (wren_cnt_a - w0 != 2) begin errors++; $display("FAIL id_pulses: got %0d, want 2", wren_cnt_a - w0); end
        checks++; if (q_a.size() != 0) begin errors++; $display("FAIL id_pending: got %0d, want 0", q_a.size()); end
        checks++; if (dec_mem_a[0] !== 8'h61) begin errors++; $display("FAIL id_dec0: got %h, want 61", dec_mem_a[0]); end
        checks++; if (dec_mem_a[1] !== 8'h61) begin errors++; $display("FAIL id_dec1: got %h, want 61", dec_mem_a[1]); end
        checks++; if (s_mem_a[1] !== 8'h01) begin errors++; $display("FAIL self_swap_s1: got %h, want 01", s_mem_a[1]); end
        checks++; if (s_mem_a[2] !== 8'h03) begin errors++; $display("FAIL swap_s2: got %h, want 03", s_mem_a[2]); end
        checks++; if (s_mem_a[3] !== 8'h02) begin errors++; $display("FAIL swap_s3: got %h, want 02", s_mem_a[3]); end
        bad = 0;
        for (int x = 0; x < 256; x++) if (s_mem_a[x] !== model_s[x]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL s_final: got %0d differing entries, want 0", bad); end
    endtask

    task automatic test_abort();
        bit ev;
        int cyc, w0;
        for (int x = 0; x < 32; x++) enc_init[x] = 8'h00;
        enc_init[0] = 8'h02;
        enc_init[1] = 8'h63;
        load(1'b0);
        model_run(2, 1'b1, 1'b0, ev);
        w0 = wren_cnt_a;
        @(negedge clk) start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        cyc = 0;
        while (finished_a !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (cyc != 11) begin errors++; $display("FAIL abort_latency: got %0d cycles, want 11", cyc); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b, want 0", valid_a); end
        checks++; if (wren_cnt_a - w0 != 1) begin errors++; $display("FAIL abort_pulses: got %0d, want 1", wren_cnt_a - w0); end
        checks++; if (dec_mem_a[0] !== 8'h00) begin errors++; $display("FAIL abort_dec0: got %h, want 00", dec_mem_a[0]); end
        checks++; if (dec_mem_a[1] !== 8'hFF) begin errors++; $display("FAIL abort_dec1: got %h, want FF (untouched)", dec_mem_a[1]); end
        q_a.delete();
    endtask

    task automatic test_no_abort();
        bit ev;
        int cyc, w0;
        for (int x = 0; x < 32; x++) enc_init[x] = 8'h02;
        load(1'b1);
        model_run(32, 1'b0, 1'b1, ev);
        w0 = wren_cnt_b;
        @(negedge clk) start_b = 1'b1;
        @(posedge clk); #1; start_b = 1'b0;
        cyc = 0;
        while (finished_b !== 1'b1 && cyc < 1000) begin @(posedge clk); #1; cyc++; end
        checks++; if (cyc != 321) begin errors++; $display("FAIL full_latency: got %0d cycles, want 321", cyc); end
        checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL full_valid: got %b, want 0", valid_b); end
        checks++; if (wren_cnt_b - w0 != 32) begin errors++; $display("FAIL full_pulses: got %0d, want 32", wren_cnt_b - w0); end
        checks++; if (q_b.size() != 0) begin errors++; $display("FAIL full_pending: got %0d, want 0", q_b.size()); end
    endtask

    task automatic test_reset_midrun();
        bit ev;
        int cyc, w0;
        for (int x = 0; x < 32; x++) enc_init[x] = 8'($urandom);
        load(1'b1);
        model_run(32, 1'b0, 1'b1, ev);
        w0 = wren_cnt_b;
        @(negedge clk) start_b = 1'b1;
        @(posedge clk); #1; start_b = 1'b0;
        repeat (35) @(posedge clk);
        #1;
        checks++; if (s_wren_b !== 1'b1) begin errors++; $display("FAIL midrun_in_wr_i: s_wren=%b, want 1", s_wren_b); end
        reset = 1'b1;
        #1;
        checks++;
        if ({s_addr_b, s_in_b, s_wren_b, enc_addr_b, dec_addr_b, dec_in_b, dec_wren_b, finished_b, valid_b} !== 37'd1) begin
            errors++;
            $display("FAIL midrun_reset: outputs=%h, want %h", {s_addr_b, s_in_b, s_wren_b, enc_addr_b,
                     dec_addr_b, dec_in_b, dec_wren_b, finished_b, valid_b}, 37'd1);
        end
        checks++; if (wren_cnt_b - w0 != 3) begin errors++; $display("FAIL midrun_pulses: got %0d, want 3", wren_cnt_b - w0); end
        checks++; if (q_b.size() != 29) begin errors++; $display("FAIL midrun_pending: got %0d, want 29", q_b.size()); end
        q_b.delete();
        @(negedge clk) reset = 1'b0;
        load(1'b1);
        model_run(32, 1'b0, 1'b1, ev);
        w0 = wren_cnt_b;
        @(negedge clk) start_b = 1'b1;
        @(posedge clk); #1; start_b = 1'b0;
        cyc = 0;
        while (finished_b !== 1'b1 && cyc < 1000) begin @(posedge clk); #1; cyc++; end
        checks++; if (cyc != 321) begin errors++; $display("FAIL rerun_latency: got %0d cycles, want 321", cyc); end
        checks++; if (wren_cnt_b - w0 != 32) begin errors++; $display("FAIL rerun_pulses: got %0d, want 32", wren_cnt_b - w0); end
        checks++; if (q_b.size() != 0) begin errors++; $display("FAIL rerun_pending: got %0d, want 0", q_b.size()); end
        checks++; if (valid_b !== ev) begin errors++; $display("FAIL rerun_valid: got %b, want %b", valid_b, ev); end
    endtask

    task automatic test_restart_guard();
        bit ev;
        int cyc, w0;
        for (int x = 0; x < 32; x++) enc_init[x] = 8'h00;
        enc_init[0] = 8'h63;
        enc_init[1] = 8'h64;
        load(1'b0);
        model_run(2, 1'b1, 1'b0, ev);
        w0 = wren_cnt_a;
        @(negedge clk) start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        cyc = 0;
        while (finished_a !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (cyc == 4) start_a = 1'b1;
        end
        checks++; if (cyc != 21) begin errors++; $display("FAIL guard_latency: got %0d cycles, want 21", cyc); end
        checks++; if (wren_cnt_a - w0 != 2) begin errors++; $display("FAIL guard_pulses: got %0d, want 2", wren_cnt_a - w0); end
        checks++; if (q_a.size() != 0) begin errors++; $display("FAIL guard_pending: got %0d, want 0", q_a.size()); end
        repeat (30) @(posedge clk);
        #1;
        checks++; if (finished_a !== 1'b1) begin errors++; $display("FAIL hold_finished: got %b, want 1", finished_a); end
        checks++; if (wren_cnt_a - w0 != 2) begin errors++; $display("FAIL hold_no_restart: got %0d pulses, want 2", wren_cnt_a - w0); end
        start_a = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        init_a  = 1'b0;
        init_b  = 1'b0;
        test_reset();
        test_identity();
        test_abort();
        test_no_abort();
        test_reset_midrun();
        test_restart_guard();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
